// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache-to-SDRAM block-transfer subsystem.
// Holds the burst state encoding, the error codes reported on err_code and
// the default geometry (block address, word offset and data widths) that
// both the cache controller and the memory responder are built with.
package cache_mem_pkg;

    localparam int unsigned DEF_BLOCK_ADDR_W = 11;
    localparam int unsigned DEF_OFFSET_W     = 5;
    localparam int unsigned DEF_DATA_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_BURST = 2'd1,
        ST_RD_BURST = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_SEQ   = 2'd1;
    localparam logic [1:0] ERR_PROTO = 2'd2;
    localparam logic [1:0] ERR_GAP   = 2'd3;

endpackage

// File: rtl/mem_read_pipe.sv
// Fixed-latency read return path: a DEPTH-stage shift register of
// {valid, data}. Every stage advances each cycle, so back-to-back reads
// are each delivered exactly DEPTH cycles after they enter.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (clears all stages)
//   i_vld, i_data   entry stage, sampled every clock edge
//   o_vld, o_data   last stage
module mem_read_pipe #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_data
);

    logic [DEPTH-1:0] r_vld;
    logic [WIDTH-1:0] r_data [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_vld[0]  <= i_vld;
            r_data[0] <= i_data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_data[i] <= r_data[i-1];
            end
        end
    end

    assign o_vld  = r_vld[DEPTH-1];
    assign o_data = r_data[DEPTH-1];

endmodule

// File: rtl/sdram_block_responder.sv
// Main-memory end of the cache block-transfer interface: a word-strobed
// memory that also tracks full-block bursts and flags protocol violations.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   memstrb           one-cycle word strobe; each strobe is one access
//   wr_rd_sdram       1 = write, 0 = read (with memstrb)
//   blk_addr, offset  word address {blk_addr, offset}
//   wdata             write data (with memstrb)
//   rdata, rdata_vld  read data, READ_LAT cycles after the read strobe
//   busy              burst in progress (burst states and DONE)
//   burst_done        one-cycle pulse when a full block has completed
//   burst_err         sticky error flag, cleared only by reset
//   err_code          first error seen (see cache_mem_pkg ERR_*)
module sdram_block_responder
    import cache_mem_pkg::*;
#(
    parameter int unsigned BLOCK_ADDR_W = DEF_BLOCK_ADDR_W,
    parameter int unsigned OFFSET_W     = DEF_OFFSET_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned READ_LAT     = 2,
    parameter int unsigned GAP_MAX      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    memstrb,
    input  logic                    wr_rd_sdram,
    input  logic [BLOCK_ADDR_W-1:0] blk_addr,
    input  logic [OFFSET_W-1:0]     offset,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DATA_W-1:0]       rdata,
    output logic                    rdata_vld,
    output logic                    busy,
    output logic                    burst_done,
    output logic                    burst_err,
    output logic [1:0]              err_code
);

    localparam int unsigned ADDR_W = BLOCK_ADDR_W + OFFSET_W;
    localparam int unsigned CNT_W  = OFFSET_W + 1;
    localparam int unsigned GAP_W  = $clog2(GAP_MAX + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(1 << OFFSET_W);

    logic [DATA_W-1:0]       r_mem [1 << ADDR_W];

    state_t                  r_state;
    logic                    r_busy;
    logic [BLOCK_ADDR_W-1:0] r_blk;
    logic                    r_dir;
    logic [OFFSET_W-1:0]     r_exp;
    logic [CNT_W-1:0]        r_cnt;
    logic [GAP_W-1:0]        r_gap;
    logic                    r_done;
    logic                    r_err;
    logic [1:0]              r_code;

    logic [ADDR_W-1:0]       w_addr;
    logic                    w_wr_en;
    logic                    w_rd_en;
    logic [DATA_W-1:0]       w_rd_data;
    logic                    w_same;
    logic [CNT_W-1:0]        w_cnt_next;
    logic                    w_last;
    logic                    w_pipe_vld;
    logic [DATA_W:0]         w_pipe_data;
    logic                    w_pipe_last;

    assign w_addr     = {blk_addr, offset};
    assign w_wr_en    = memstrb && wr_rd_sdram;
    assign w_rd_en    = memstrb && !wr_rd_sdram;
    assign w_rd_data  = w_rd_en ? r_mem[w_addr] : '0;
    assign w_same     = (blk_addr == r_blk) && (wr_rd_sdram == r_dir);
    assign w_cnt_next = r_cnt + 1'b1;

    // The read that completes a block carries a tag through the latency
    // pipe; its emergence marks the end of the read burst even if a new
    // burst has already started from DONE.
    assign w_last = w_rd_en && (r_state == ST_RD_BURST) && w_same &&
                    (w_cnt_next == FULL_CNT);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_addr] <= wdata;
        end
    end

    mem_read_pipe #(
        .DEPTH (READ_LAT),
        .WIDTH (DATA_W + 1)
    ) u_read_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (w_rd_en),
        .i_data ({w_last, w_rd_data}),
        .o_vld  (w_pipe_vld),
        .o_data (w_pipe_data)
    );

    assign w_pipe_last = w_pipe_vld && w_pipe_data[DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_blk   <= '0;
            r_dir   <= 1'b0;
            r_exp   <= '0;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_code  <= ERR_NONE;
        end else begin
            // Write bursts finish on leaving DONE; read bursts when the
            // tagged final read is delivered.
            r_done <= w_pipe_last || ((r_state == ST_DONE) && r_dir);

            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (memstrb) begin
                        r_state <= wr_rd_sdram ? ST_WR_BURST : ST_RD_BURST;
                        r_busy  <= 1'b1;
                        r_blk   <= blk_addr;
                        r_dir   <= wr_rd_sdram;
                        r_exp   <= offset + 1'b1;
                        r_cnt   <= CNT_W'(1);
                        r_gap   <= '0;
                    end else if (r_state == ST_DONE && (r_dir || w_pipe_last)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_WR_BURST, ST_RD_BURST: begin
                    if (memstrb) begin
                        r_gap <= '0;
                        if (!w_same) begin
                            if (!r_err) begin
                                r_err  <= 1'b1;
                                r_code <= ERR_PROTO;
                            end
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            if (offset != r_exp && !r_err) begin
                                r_err  <= 1'b1;
                                r_code <= ERR_SEQ;
                            end
                            r_exp <= r_exp + 1'b1;
                            r_cnt <= w_cnt_next;
                            if (w_cnt_next == FULL_CNT) begin
                                r_state <= ST_DONE;
                            end
                        end
                    end else if (r_gap == GAP_W'(GAP_MAX - 1)) begin
                        if (!r_err) begin
                            r_err  <= 1'b1;
                            r_code <= ERR_GAP;
                        end
                        r_gap   <= '0;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
            endcase
        end
    end

    assign rdata      = w_pipe_data[DATA_W-1:0];
    assign rdata_vld  = w_pipe_vld;
    assign busy       = r_busy;
    assign burst_done = r_done;
    assign burst_err  = r_err;
    assign err_code   = r_code;

endmodule

// File: tb/tb_sdram_block_responder.sv
// Directed bench for sdram_block_responder: a vector table for a short
// write/read/protocol-error sequence, then hand-written burst scenarios.
module tb_sdram_block_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memstrb = 1'b0;
    logic        wr_rd_sdram = 1'b0;
    logic [10:0] blk_addr = '0;
    logic [4:0]  offset = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata;
    logic        rdata_vld;
    logic        busy;
    logic        burst_done;
    logic        burst_err;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    sdram_block_responder #(
        .BLOCK_ADDR_W (11),
        .OFFSET_W     (5),
        .DATA_W       (8),
        .READ_LAT     (2),
        .GAP_MAX      (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .memstrb     (memstrb),
        .wr_rd_sdram (wr_rd_sdram),
        .blk_addr    (blk_addr),
        .offset      (offset),
        .wdata       (wdata),
        .rdata       (rdata),
        .rdata_vld   (rdata_vld),
        .busy        (busy),
        .burst_done  (burst_done),
        .burst_err   (burst_err),
        .err_code    (err_code)
    );

    typedef struct {
        logic        strb;
        logic        wr;
        logic [10:0] blk;
        logic [4:0]  off;
        logic [7:0]  wd;
        logic        vld;
        logic [7:0]  rd;
        logic        bsy;
        logic        done;
        logic        err;
        logic [1:0]  code;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          vld_cyc[$];
    logic [7:0]  vld_dat[$];
    int          strb_cyc[32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        done_cnt = 0;
        done_cyc = -1;
        vld_cyc.delete();
        vld_dat.delete();
    endtask

    // One clock: outputs observed 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (burst_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rdata_vld) begin
            vld_cyc.push_back(cyc);
            vld_dat.push_back(rdata);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe(input logic wr, input logic [10:0] b, input logic [4:0] o,
                          input logic [7:0] d);
        memstrb = 1'b1;
        wr_rd_sdram = wr;
        blk_addr = b;
        offset = o;
        wdata = d;
        tick();
        memstrb = 1'b0;
    endtask

    task automatic do_reset();
        memstrb = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic check_mem(input string name, input logic [10:0] b, input logic [4:0] o,
                             input logic [7:0] exp);
        logic [15:0] a;
        a = {b, o};
        check(name, 32'(dut.r_mem[a]), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vt[8];
        int   last;
        logic [4:0] seq[32];

        // ---------------- reset state ----------------
        #2 rst = 1'b1;
        #1;
        check("rst_rdata", 32'(rdata), 0);
        check("rst_vld", 32'(rdata_vld), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(burst_done), 0);
        check("rst_err", 32'(burst_err), 0);
        check("rst_code", 32'(err_code), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ---------------- vector table ----------------
        //            strb wr  blk      off  wd      vld rd     bsy done err code
        vt[0] = '{1'b1, 1'b1, 11'h055, 5'd0, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0};
        vt[1] = '{1'b1, 1'b1, 11'h055, 5'd1, 8'h4D, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0};
        vt[2] = '{1'b1, 1'b0, 11'h055, 5'd1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd2};
        vt[3] = '{1'b0, 1'b0, 11'h055, 5'd0, 8'h00, 1'b1, 8'h4D, 1'b0, 1'b0, 1'b1, 2'd2};
        vt[4] = '{1'b1, 1'b0, 11'h055, 5'd0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd2};
        vt[5] = '{1'b1, 1'b0, 11'h055, 5'd0, 8'h00, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 2'd2};
        vt[6] = '{1'b0, 1'b0, 11'h055, 5'd0, 8'h00, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 2'd2};
        vt[7] = '{1'b0, 1'b0, 11'h055, 5'd0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd2};
        for (int i = 0; i < 8; i++) begin
            memstrb = vt[i].strb;
            wr_rd_sdram = vt[i].wr;
            blk_addr = vt[i].blk;
            offset = vt[i].off;
            wdata = vt[i].wd;
            tick();
            check($sformatf("vec%0d_vld", i), 32'(rdata_vld), 32'(vt[i].vld));
            if (vt[i].vld) check($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vt[i].rd));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].bsy));
            check($sformatf("vec%0d_done", i), 32'(burst_done), 32'(vt[i].done));
            check($sformatf("vec%0d_err", i), 32'(burst_err), 32'(vt[i].err));
            check($sformatf("vec%0d_code", i), 32'(err_code), 32'(vt[i].code));
        end
        memstrb = 1'b0;

        // ---------------- write burst, strobes every other cycle ----------------
        do_reset();
        last = 0;
        for (int k = 0; k < 32; k++) begin
            strobe(1'b1, 11'h123, 5'(k), 8'(k) ^ 8'hA5);
            last = cyc;
            idle(1);
        end
        idle(3);
        for (int k = 0; k < 32; k++)
            check_mem($sformatf("wr_mem%0d", k), 11'h123, 5'(k), 8'(k) ^ 8'hA5);
        check("wr_done_cnt", 32'(done_cnt), 1);
        check("wr_done_cyc", 32'(done_cyc), 32'(last + 1));
        check("wr_err", 32'(burst_err), 0);
        check("wr_busy_end", 32'(busy), 0);

        // ---------------- read burst, back-to-back strobes ----------------
        clear_mon();
        for (int k = 0; k < 32; k++) begin
            strobe(1'b0, 11'h123, 5'(k), 8'h00);
            strb_cyc[k] = cyc;
        end
        check("rd_busy_mid", 32'(busy), 1);
        idle(5);
        check("rd_vld_count", 32'(vld_cyc.size()), 32);
        for (int k = 0; k < 32 && k < vld_cyc.size(); k++) begin
            check($sformatf("rd_lat%0d", k), 32'(vld_cyc[k]), 32'(strb_cyc[k] + 1));
            check($sformatf("rd_data%0d", k), 32'(vld_dat[k]), 32'(8'(k) ^ 8'hA5));
        end
        check("rd_done_cnt", 32'(done_cnt), 1);
        check("rd_done_cyc", 32'(done_cyc), 32'(strb_cyc[31] + 2));
        check("rd_err", 32'(burst_err), 0);
        check("rd_busy_end", 32'(busy), 0);

        // ---------------- wrapped start ----------------
        clear_mon();
        for (int k = 0; k < 32; k++) begin
            strobe(1'b1, 11'h2AA, 5'((k + 30) % 32), 8'(k) + 8'h10);
            last = cyc;
        end
        idle(3);
        check("wrap_done_cnt", 32'(done_cnt), 1);
        check("wrap_done_cyc", 32'(done_cyc), 32'(last + 1));
        check("wrap_err", 32'(burst_err), 0);
        check_mem("wrap_mem30", 11'h2AA, 5'd30, 8'h10);
        check_mem("wrap_mem29", 11'h2AA, 5'd29, 8'h2F);

        // ---------------- offset skip ----------------
        clear_mon();
        seq[0] = 5'd0;
        seq[1] = 5'd1;
        for (int k = 2; k < 31; k++) seq[k] = 5'(k + 1);
        seq[31] = 5'd2;
        for (int k = 0; k < 32; k++) begin
            strobe(1'b1, 11'h1F0, seq[k], 8'h77);
            if (k == 1) check("skip_err_before", 32'(burst_err), 0);
            if (k == 2) begin
                check("skip_err_at3", 32'(burst_err), 1);
                check("skip_code_at3", 32'(err_code), 1);
            end
        end
        idle(3);
        check("skip_done_cnt", 32'(done_cnt), 1);
        check("skip_code_end", 32'(err_code), 1);

        // ---------------- gap timeout ----------------
        do_reset();
        for (int k = 0; k < 5; k++) strobe(1'b1, 11'h300, 5'(k), 8'h11);
        idle(7);
        check("gap_busy_7", 32'(busy), 1);
        check("gap_err_7", 32'(burst_err), 0);
        idle(1);
        check("gap_busy_8", 32'(busy), 0);
        check("gap_err_8", 32'(burst_err), 1);
        check("gap_code_8", 32'(err_code), 3);
        idle(3);
        check("gap_done_cnt", 32'(done_cnt), 0);

        // ---------------- mid-burst asynchronous reset ----------------
        do_reset();
        for (int k = 0; k < 10; k++) strobe(1'b0, 11'h123, 5'(k), 8'h00);
        check("mrst_vld_before", 32'(rdata_vld), 1);
        check("mrst_busy_before", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("mrst_vld", 32'(rdata_vld), 0);
        check("mrst_rdata", 32'(rdata), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_done", 32'(burst_done), 0);
        check("mrst_err", 32'(burst_err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_mon();
        idle(4);
        check("mrst_no_vld", 32'(vld_cyc.size()), 0);
        for (int k = 5; k < 8; k++) strobe(1'b0, 11'h123, 5'(k), 8'h00);
        idle(3);
        check("mrst_rb_count", 32'(vld_cyc.size()), 3);
        for (int k = 0; k < 3 && k < vld_dat.size(); k++)
            check($sformatf("mrst_rb%0d", k), 32'(vld_dat[k]), 32'(8'(k + 5) ^ 8'hA5));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sdram_block_responder.md
Name: sdram_block_responder

Overview:
- Main-memory end of the cache-to-SDRAM block-transfer interface. The cache controller initiates; this block responds.
- It services strobed single-word accesses that arrive as a full-block burst: it stores write-back words and returns line-fill words after a fixed read latency.
- It tracks burst progress and flags protocol violations. It serves as the SDRAM model and bus monitor in the cache subsystem.

Parameters:
- BLOCK_ADDR_W, 11, width of the block address (tag+index) presented with each burst.
- OFFSET_W, 5, word-offset width; one block is 2**OFFSET_W words.
- DATA_W, 8, word width.
- READ_LAT, 2, cycles from read strobe to rdata_vld; legal range 1..4.
- GAP_MAX, 8, maximum idle cycles between strobes inside a burst before a timeout abort.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- memstrb  in  1  one-cycle word strobe from the cache controller.
- wr_rd_sdram  in  1  1 = write (cache to memory), 0 = read; sampled with memstrb.
- blk_addr  in  BLOCK_ADDR_W  block address; must stay constant for the whole burst.
- offset  in  OFFSET_W  word offset within the block.
- wdata  in  DATA_W  write data; sampled with memstrb.
- rdata  out  DATA_W  read data.
- rdata_vld  out  1  one-cycle qualifier for rdata.
- busy  out  1  high while a burst is in progress.
- burst_done  out  1  one-cycle pulse after the last word of a burst completes.
- burst_err  out  1  sticky error flag; cleared only by reset.
- err_code  out  2  first error seen: 0 none, 1 offset out of sequence, 2 direction/block change mid-burst, 3 gap timeout.

Behaviour:
- Reset values: rdata=0, rdata_vld=0, busy=0, burst_done=0, burst_err=0, err_code=0, state=IDLE, word counter=0, gap counter=0, latency pipe cleared. The memory array is not reset.
- Strobe semantics: every memstrb=1 cycle is one word access at address {blk_addr, offset}, whatever the state.
- Write strobe: mem written at that clock edge.
- Read strobe: mem read at that clock edge. rdata/rdata_vld appear exactly READ_LAT cycles after the strobe edge. The latency path is a READ_LAT-deep pipe, so back-to-back strobes on consecutive cycles are each served.
- Read-after-write to the same address on consecutive strobes returns the new data.
- State machine:
  - IDLE, strobe seen → WR_BURST or RD_BURST by wr_rd_sdram. Latch blk_addr, direction, expected offset = offset+1, count = 1.
  - WR_BURST/RD_BURST, each strobe → count+1, expected offset +1 modulo 2**OFFSET_W.
  - On the strobe making count == 2**OFFSET_W → DONE.
  - DONE, write burst: burst_done pulses for one cycle, then → IDLE.
  - DONE, read burst: waits until the last rdata_vld has issued, pulses burst_done in the cycle after it, then → IDLE.
- The first strobe of a burst need not use offset 0. The offset wraps, and all 2**OFFSET_W words are still required.
- busy=1 in WR_BURST, RD_BURST and DONE.
- Errors (all sticky; err_code keeps the first error):
  - Offset mismatch → code 1. The access is still performed and the burst continues.
  - wr_rd_sdram or blk_addr differs from the latched value → code 2. The access is performed, the burst aborts to IDLE with no burst_done, and that strobe does not start a new burst.
  - Gap counter reaches GAP_MAX with no strobe in a burst state → code 3; abort to IDLE with no burst_done. The gap counter resets on every strobe.
  - Reads already in the latency pipe at abort still deliver.
- Strobe in the DONE cycle: served as a memory access and starts a new burst (DONE → WR/RD_BURST directly). The burst_done pulse still fires.
- Reset mid-burst: all state returns to reset values immediately. In-flight reads are dropped. Memory contents are preserved.
- Counter width is OFFSET_W+1 so the full-block count is representable without overflow.

Decomposition:
- Shared package cache_mem_pkg holds:
  - state encodings (IDLE, WR_BURST, RD_BURST, DONE);
  - err_code constants (ERR_NONE, ERR_SEQ, ERR_PROTO, ERR_GAP);
  - default OFFSET_W, DATA_W and BLOCK_ADDR_W, shared with cache_fsm.
- One natural sub-module, mem_read_pipe: a READ_LAT-stage shift of {valid, data}.
- The memory array and burst FSM stay in the top module.

Test Plan:
- Write burst: 32 strobes every other cycle, blk_addr=0x123, offsets 0..31, wdata=offset^0xA5. Backdoor mem[{0x123,k}]=k^0xA5 for all k; one burst_done pulse 2 cycles after the last strobe; burst_err=0.
- Read burst after the above, READ_LAT=2, same address: rdata_vld 32 times, each 2 cycles after its strobe, rdata=k^0xA5. burst_done in the cycle after the 32nd rdata_vld.
- Wrapped start: strobes at offsets 30,31,0..29. No error; burst_done after the 32nd strobe.
- Offset skip: offsets 0,1,3,… → burst_err=1, err_code=1 on the strobe at offset 3; the burst still completes with burst_done.
- Gap timeout: 5 strobes then none for 8 cycles → err_code=3, busy falls, no burst_done.
- Mid-burst reset: rst pulse after 10 read strobes → all outputs 0 asynchronously, no further rdata_vld. Previously written memory still reads back correctly afterwards.
